ripple_count_sampler: RTL
=========================

# ripple_count_sampler

Captures the value of a free-running asynchronous ripple down counter (3-bit by default) into the system clock domain and turns its decrements into clean, handshaked tick-count events. It sits directly downstream of the ripple counter, whose bits change at staggered times. It synchronises every bit, accepts a value only once it has been stable, and derives elapsed-tick deltas and wrap (underflow) indications. It also keeps a running tick accumulator for consumers in the `clk` domain.

## Interface
- `CW`, 3 — width of the ripple counter input.
- `SYNC_STAGES`, 2 — flops per bit in the synchroniser; minimum 2.
- `STABLE_CYCLES`, 2 — consecutive identical synchronised samples required before acceptance; minimum 1.
- `SW`, 8 — width of the per-event step field; saturating.
- `EXT_W`, 16 — width of the running tick accumulator.

Ports:
- `clk` in 1 — system clock; all logic on the rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `en` in 1 — sampling enable.
- `cnt_in` in CW — ripple counter value, asynchronous to `clk`.
- `out_valid` out 1 — an event record is held.
- `out_ready` in 1 — the consumer accepts the record.
- `out_count` out CW — accepted counter value.
- `out_steps` out SW — ticks elapsed since the previous record's value; saturates at 2^SW−1.
- `out_wrap` out 1 — the counter passed through 0 → 2^CW−1 at least once.
- `out_merged` out 1 — the record coalesces two or more events.
- `ext_count` out EXT_W — total ticks since priming; wraps modulo 2^EXT_W.

## Operation
- **Synchronisation and filtering**
  - Each bit of `cnt_in` passes through its own `SYNC_STAGES`-flop synchroniser, giving `s`.
  - A stability filter holds a candidate `cand` and a counter `stab`.
    - If `s != cand`: `cand <= s`, `stab <= 0`.
    - Otherwise: `stab` increments, saturating.
  - `cand` is *accepted* on the cycle in which `stab` reaches `STABLE_CYCLES`.
  - An accepted value is consumed once; it is not re-accepted until `cand` changes again.
- **States**
  - `PRIME`: entered on reset, and whenever `en` is 0. The first accepted value is loaded into `last`; no event is produced; go to `TRACK`.
  - `TRACK`: on acceptance of a value `v != last`:
    - `d = (last − v) mod 2^CW`, computed in CW bits;
    - `wrap = (v > last)`;
    - `ext_count += d`;
    - `last <= v`;
    - an event record is produced.
  - An accepted `v == last` produces nothing.
- **While `en` = 0:** the synchroniser keeps running, the filter is held cleared, `ext_count` holds, and the state is forced to `PRIME`. Any pending record stays valid.
- **Output register**
  - Empty, or being consumed this cycle (`out_valid && out_ready`), when an event arrives: load `{v, d, wrap, merged=0}`.
  - Full and not consumed when an event arrives: coalesce in place:
    - `out_count <= v`;
    - `out_steps <= sat(out_steps + d)`;
    - `out_wrap |= wrap`;
    - `out_merged <= 1`.
  - The handshake with no new event clears `out_valid`.
- **Aliasing limit:** the upstream counter must advance fewer than 2^CW ticks between acceptances. Larger advances alias silently; this is not detected.

## Timing
- **Reset values:** all outputs, `last`, `cand`, `stab` and the synchroniser flops are 0; the state is `PRIME`.
- **Latency:** `cnt_in` is stable from at least setup before edge 0. `out_valid` and `out_count` update at edge `SYNC_STAGES + STABLE_CYCLES + 1`, which is edge 5 at defaults. A setup violation at edge 0 may add exactly one cycle.
- **Throughput:** at most one acceptance per `STABLE_CYCLES + 1` cycles.
- **Handshake:** record fields are stable while `out_valid && !out_ready`, except for coalescing. Coalescing updates all four fields in a single edge.
- **Reset mid-operation:** any record, including a pending one, is dropped immediately and asynchronously. Operation restarts in `PRIME`.

## Structure
- Package `ripple_cnt_pkg` holds:
  - the state enum `{PRIME, TRACK}`;
  - the packed event record typedef `{count, steps, wrap, merged}`, parameterised via CW/SW localparams at the defaults;
  - the function `down_delta(last, v)` computing the modulo difference.
- Sub-module `bit_sync` is one `SYNC_STAGES`-deep single-bit synchroniser with async reset. It is instantiated CW times.

## Test plan
- **Priming:** reset, `en`=1, `cnt_in`=5 held → `out_valid` stays 0; `ext_count`=0 after 20 cycles.
- **Single decrement:** primed at 5, `cnt_in`→4 → at edge 5, `out_valid`=1, `out_count`=4, `out_steps`=1, `out_wrap`=0; `ext_count`=1.
- **Wrap:** primed at 1, `cnt_in`→6 (ticks 1→0→7→6) → `out_steps`=3, `out_wrap`=1; `ext_count`=3.
- **Glitch rejection:** primed at 4, a 1-cycle excursion to 7 followed by 3 → a single event with `out_count`=3, `out_steps`=1; no event carries 7.
- **Coalescing:**
  - `out_ready`=0, events 5→4 then 4→2 → one record: `out_count`=2, `out_steps`=3, `out_merged`=1.
  - `out_ready` high in the cycle the second event arrives → two separate records, both with `out_merged`=0.
- **Reset mid-operation:** assert `rst` while `out_valid`=1 → `out_valid` goes to 0 immediately and `ext_count`=0; after release, the first value only primes and produces no event.

Source files
------------

// File: rtl/ripple_cnt_pkg.sv
// Shared types and helpers for the ripple counter sampler: FSM states,
// the event record layout at default widths, and the modulo down-count delta.
package ripple_cnt_pkg;

    localparam int unsigned CW_DEF  = 3;
    localparam int unsigned SW_DEF  = 8;
    localparam int unsigned DELTA_W = 32;

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef struct packed {
        logic [CW_DEF-1:0] count;
        logic [SW_DEF-1:0] steps;
        logic              wrap;
        logic              merged;
    } event_rec_t;

    // Ticks elapsed going down from last to v, reduced modulo 2^w.
    function automatic logic [DELTA_W-1:0] down_delta(
        input logic [DELTA_W-1:0] last,
        input logic [DELTA_W-1:0] v,
        input int unsigned        w
    );
        logic [DELTA_W-1:0] mask;
        mask = (w >= DELTA_W) ? '1 : ((DELTA_W'(1) << w) - DELTA_W'(1));
        return (last - v) & mask;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser for bringing one ripple counter bit
// into the clk domain; cleared by the asynchronous reset.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple down counter, filters out staggered-bit
// transients, and emits handshaked tick-count events plus a running total.
module ripple_count_sampler
    import ripple_cnt_pkg::*;
#(
    parameter int unsigned CW            = 3,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned SW            = 8,
    parameter int unsigned EXT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CW-1:0]    cnt_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic [SW-1:0]    out_steps,
    output logic             out_wrap,
    output logic             out_merged,
    output logic [EXT_W-1:0] ext_count
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 2);
    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);
    localparam int unsigned SUM_W  = ((SW > CW) ? SW : CW) + 1;

    localparam logic [STAB_W-1:0] STAB_ACCEPT = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_MAX    = STAB_W'(STABLE_CYCLES + 1);
    localparam logic [FILL_W-1:0] FILL_DONE   = FILL_W'(SYNC_STAGES);
    localparam logic [SUM_W-1:0]  STEPS_MAX   = SUM_W'({SW{1'b1}});

    logic [CW-1:0] s;

    for (genvar i = 0; i < CW; i++) begin : g_sync
        bit_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk(clk),
            .rst(rst),
            .d  (cnt_in[i]),
            .q  (s[i])
        );
    end

    // The filter waits until the synchronisers have flushed their reset zeros,
    // otherwise that stale zero would be accepted as a real counter value.
    logic [FILL_W-1:0] fill_q;
    logic [CW-1:0]     cand_q;
    logic [STAB_W-1:0] stab_q;
    logic              filter_run;
    logic              accept;

    assign filter_run = en && (fill_q == FILL_DONE);
    assign accept     = filter_run && (stab_q == STAB_ACCEPT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= '0;
            cand_q <= '0;
            stab_q <= '0;
        end else begin
            if (fill_q != FILL_DONE) begin
                fill_q <= fill_q + 1'b1;
            end
            if (!filter_run) begin
                cand_q <= '0;
                stab_q <= '0;
            end else if (s != cand_q) begin
                cand_q <= s;
                stab_q <= '0;
            end else if (stab_q != STAB_MAX) begin
                // Saturating one past the accept level makes acceptance one-shot.
                stab_q <= stab_q + 1'b1;
            end
        end
    end

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] last_q;
    logic [CW-1:0] delta;
    logic          wrap_ev;
    logic          event_ev;
    logic [SW-1:0] fresh_steps;
    logic [SW-1:0] merged_steps;
    logic [SUM_W-1:0] steps_sum;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latches.
        state_d      = state_q;
        event_ev     = 1'b0;
        delta        = CW'(down_delta(DELTA_W'(last_q), DELTA_W'(cand_q), CW));
        wrap_ev      = (cand_q > last_q);
        steps_sum    = SUM_W'(out_steps) + SUM_W'(delta);
        fresh_steps  = (SUM_W'(delta) > STEPS_MAX) ? SW'(STEPS_MAX) : SW'(delta);
        merged_steps = (steps_sum > STEPS_MAX) ? SW'(STEPS_MAX) : SW'(steps_sum);

        if (!en) begin
            state_d = PRIME;
        end else if (accept) begin
            case (state_q)
                PRIME:   state_d = TRACK;
                TRACK:   event_ev = (cand_q != last_q);
                default: state_d = PRIME;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PRIME;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= cand_q;
            end
        end
    end

    // Output record: fresh load when empty or draining, else coalesce in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_count  <= '0;
            out_steps  <= '0;
            out_wrap   <= 1'b0;
            out_merged <= 1'b0;
            ext_count  <= '0;
        end else if (event_ev) begin
            ext_count <= ext_count + EXT_W'(delta);
            out_valid <= 1'b1;
            out_count <= cand_q;
            if (!out_valid || out_ready) begin
                out_steps  <= fresh_steps;
                out_wrap   <= wrap_ev;
                out_merged <= 1'b0;
            end else begin
                out_steps  <= merged_steps;
                out_wrap   <= out_wrap | wrap_ev;
                out_merged <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
